// File: rtl/beat_gen.sv
// beat_gen
// Divides clk by a runtime-programmable period to produce a one-cycle beat
// strobe, and keeps a free-running beat-phase index for pattern sequencers.
//
// Ports:
//   clk           in   system clock, all state updates on rising edge
//   reset         in   synchronous active-high reset
//   en            in   count enable; 0 pauses counter and phase
//   clear         in   synchronous restart of counter and phase
//   period        in   requested period in clock cycles (0 = stalled)
//   period_load   in   one-cycle strobe capturing period into pending
//   beat          out  one-cycle strobe, combinational from state
//   phase         out  registered beat index
//   wrap          out  beat on the last phase step
//   active_period out  period currently in force
module beat_gen #(
    parameter int WIDTH          = 24,
    parameter int DEFAULT_PERIOD = 3125000,
    parameter int PHASE_BITS     = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clear,
    input  logic [WIDTH-1:0]      period,
    input  logic                  period_load,
    output logic                  beat,
    output logic [PHASE_BITS-1:0] phase,
    output logic                  wrap,
    output logic [WIDTH-1:0]      active_period
);

    localparam logic [WIDTH-1:0]      DEF_PERIOD = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0]      CNT_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PHASE_BITS-1:0] PH_ONE     = {{(PHASE_BITS-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      count_q, count_d;
    logic [WIDTH-1:0]      active_period_q, active_period_d;
    logic [WIDTH-1:0]      pending_q, pending_d;
    logic                  pending_valid_q, pending_valid_d;
    logic [PHASE_BITS-1:0] phase_q, phase_d;

    logic period_zero;
    logic tc;
    logic apply;

    assign period_zero = (active_period_q == '0);
    // Subtraction only matters when the period is non-zero; the zero case
    // is masked so the wrapped all-ones value never produces a terminal count.
    assign tc    = !period_zero && (count_q == (active_period_q - CNT_ONE));
    assign beat  = en && tc && !clear;
    assign wrap  = beat && (phase_q == '1);
    // Period changes only land on an interval boundary, on clear, or while
    // stalled, so the counter never runs past a newly shortened period.
    assign apply = beat || clear || period_zero;

    assign phase         = phase_q;
    assign active_period = active_period_q;

    always_comb begin
        count_d         = count_q;
        active_period_d = active_period_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        phase_d         = phase_q;

        if (period_load) begin
            pending_d       = period;
            pending_valid_d = 1'b1;
        end

        if (apply) begin
            // A load arriving on the apply edge is newer than pending.
            if (period_load) begin
                active_period_d = period;
            end else if (pending_valid_q) begin
                active_period_d = pending_q;
            end
            pending_valid_d = 1'b0;
        end

        if (clear) begin
            count_d = '0;
            phase_d = '0;
        end else if (en) begin
            if (tc) begin
                count_d = '0;
                phase_d = phase_q + PH_ONE;
            end else if (!period_zero) begin
                count_d = count_q + CNT_ONE;
            end else begin
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q         <= '0;
            active_period_q <= DEF_PERIOD;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            phase_q         <= '0;
        end else begin
            count_q         <= count_d;
            active_period_q <= active_period_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            phase_q         <= phase_d;
        end
    end

endmodule

// File: tb/tb_beat_gen.sv
module tb_beat_gen;

    localparam int WIDTH = 8;
    localparam int PB    = 5;

    logic             clk = 1'b0;
    logic             reset, en, clear, period_load;
    logic [WIDTH-1:0] period;
    logic             beat, wrap;
    logic [PB-1:0]    phase;
    logic [WIDTH-1:0] active_period;

    int errors = 0;
    int checks = 0;
    logic w;

    beat_gen #(.WIDTH(WIDTH), .DEFAULT_PERIOD(10), .PHASE_BITS(PB)) dut (
        .clk(clk), .reset(reset), .en(en), .clear(clear),
        .period(period), .period_load(period_load),
        .beat(beat), .phase(phase), .wrap(wrap),
        .active_period(active_period)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs enabled cycles until beat is seen; reports in which cycle (1-based,
    // counting the current one) it appeared, and advances past that edge.
    task automatic wait_beat(input int exp_n, input string tag, output logic w_at);
        int n;
        n = 0;
        w_at = 1'b0;
        for (int i = 1; i <= exp_n + 20; i++) begin
            #1;
            if (beat === 1'b1) begin
                n = i;
                w_at = wrap;
                tick();
                break;
            end
            tick();
        end
        chk(tag, n, exp_n);
    endtask

    task automatic load(input logic [WIDTH-1:0] p);
        period = p;
        period_load = 1'b1;
        tick();
        period_load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; clear = 1'b0; period_load = 1'b0; period = '0;
        tick();
        #1;
        chk("reset_beat", beat, 0);
        tick();
        chk("reset_ap", active_period, 10);
        chk("reset_phase", phase, 0);
        reset = 1'b0;

        // Default period: beat in 10th cycle, phase 0->1->2
        wait_beat(10, "def_first", w);
        chk("def_phase1", phase, 1);
        wait_beat(10, "def_second", w);
        chk("def_phase2", phase, 2);
        chk("def_ap", active_period, 10);

        // Mid-interval reload: 4 at count 3, then 6 at count 5 wins
        tick(); tick(); tick();
        load(4);
        chk("reload_hold", active_period, 10);
        tick();
        load(6);
        chk("reload_hold2", active_period, 10);
        wait_beat(4, "reload_boundary", w);
        chk("reload_last_wins", active_period, 6);
        wait_beat(6, "reload_p6", w);
        load(4);
        wait_beat(5, "reload_p6_b", w);
        chk("reload_ap4", active_period, 4);
        wait_beat(4, "reload_p4", w);
        chk("reload_phase", phase, 6);

        // Phase wrap at period 2 (applied via clear)
        period = 2; period_load = 1'b1; clear = 1'b1;
        #1;
        chk("clear_beat_sup", beat, 0);
        tick();
        period_load = 1'b0; clear = 1'b0;
        chk("wrap_ap", active_period, 2);
        chk("wrap_phase0", phase, 0);
        for (int k = 0; k < 32; k++) begin
            wait_beat(2, "wrap_interval", w);
            chk("wrap_flag", w, (k == 31) ? 1 : 0);
        end
        chk("wrap_phase_ret", phase, 0);

        // Pause at count 5 for 7 cycles
        load(10);
        wait_beat(1, "pause_apply", w);
        chk("pause_ap", active_period, 10);
        repeat (5) tick();
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("pause_nobeat", beat, 0);
            tick();
        end
        chk("pause_phase", phase, 1);
        en = 1'b1;
        wait_beat(5, "pause_resume", w);
        chk("pause_phase2", phase, 2);
        // Pause exactly at terminal count: beat gated, then fires on resume
        repeat (9) tick();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("pause_tc_nobeat", beat, 0);
            tick();
        end
        en = 1'b1;
        wait_beat(1, "pause_tc_resume", w);
        chk("pause_tc_phase", phase, 3);

        // Stall with period 0, then restart with 3
        load(0);
        wait_beat(9, "stall_finish", w);
        chk("stall_ap", active_period, 0);
        begin
            int nb;
            nb = 0;
            for (int k = 0; k < 15; k++) begin
                #1;
                if (beat !== 1'b0) nb++;
                tick();
            end
            chk("stall_nobeats", nb, 0);
        end
        load(3);
        chk("stall_ap3", active_period, 3);
        wait_beat(3, "stall_first", w);
        chk("stall_phase", phase, 5);

        // Clear at tc with pending 5
        load(5);
        tick();
        clear = 1'b1;
        #1;
        chk("clear_tc_nobeat", beat, 0);
        tick();
        clear = 1'b0;
        chk("clear_ap", active_period, 5);
        chk("clear_phase", phase, 0);
        wait_beat(5, "clear_p5", w);
        chk("clear_phase1", phase, 1);

        // Reset dominates clear and load; pending must be discarded
        tick(); tick();
        reset = 1'b1; clear = 1'b1; period_load = 1'b1; period = 7;
        tick();
        reset = 1'b0; clear = 1'b0; period_load = 1'b0;
        chk("rst_ap", active_period, 10);
        chk("rst_phase", phase, 0);
        wait_beat(10, "rst_first", w);
        chk("rst_no_pending", active_period, 10);
        wait_beat(10, "rst_second", w);

        // Period 1: beat every cycle
        period = 1; period_load = 1'b1; clear = 1'b1;
        tick();
        period_load = 1'b0; clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("p1_beat", beat, 1);
            chk("p1_phase", phase, k);
            tick();
        end
        chk("p1_phase_end", phase, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
